// File: rtl/rr_x_in_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_x_in_arb_pkg                                            |
// | Purpose : Shared definitions for the round-robin NoC input arbiter:  |
// |           default sizing and FSM state encodings.                    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package rr_x_in_arb_pkg;

    // Default sizing: 5 arbitrated inputs, 3-bit index/pointer
    localparam int C_IO_SIZE_DEF = 5;
    localparam int C_IO_W_DEF    = 3;

    // Arbiter FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t C_ST_IDLE  = 1'b0;
    localparam state_t C_ST_GRANT = 1'b1;

endpackage : rr_x_in_arb_pkg
`default_nettype wire

// File: rtl/rr_x_in_arb_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_x_in_arb_prio_enc                                       |
// | Purpose : Lowest-set-bit priority encoder used on the rotated        |
// |           request vector.                                            |
// | Ports   : req   in  IO_SIZE  request vector (already rotated)        |
// |           found out 1        at least one bit of req is set          |
// |           enc   out IO_W     index of the lowest set bit (0 if none)|
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rr_x_in_arb_prio_enc
    import rr_x_in_arb_pkg::*;
#(
    parameter int IO_SIZE = C_IO_SIZE_DEF,
    parameter int IO_W    = C_IO_W_DEF
) (
    input  logic [IO_SIZE-1:0] req,
    output logic               found,
    output logic [IO_W-1:0]    enc
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        found = |req;
        enc   = '0;
        for (int i = IO_SIZE - 1; i >= 0; i--) begin
            if (req[i]) begin
                enc = IO_W'(i);
            end
        end
    end

endmodule : rr_x_in_arb_prio_enc
`default_nettype wire

// File: rtl/rr_x_in_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_x_in_arb                                                |
// | Purpose : Round-robin, packet-locking arbiter for one NoC output     |
// |           port. A grant is held until the winner's tail flit is      |
// |           accepted (or the winner withdraws its request); the        |
// |           priority pointer then moves past the released input.       |
// | Ports   : clk         in  1        rising-edge clock                 |
// |           rst_n       in  1        asynchronous active-low reset     |
// |           request     in  IO_SIZE  per-input head-flit request       |
// |           tail        in  IO_SIZE  per-input head flit is the tail   |
// |           ack         in  1        granted flit accepted this cycle  |
// |           grant       out IO_SIZE  one-hot grant (registered)        |
// |           grant_valid out 1        grant is active (registered)      |
// |           grant_idx   out IO_W     binary granted index (registered) |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rr_x_in_arb
    import rr_x_in_arb_pkg::*;
#(
    parameter int IO_SIZE = C_IO_SIZE_DEF,
    parameter int IO_W    = C_IO_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IO_SIZE-1:0] request,
    input  logic [IO_SIZE-1:0] tail,
    input  logic               ack,
    output logic [IO_SIZE-1:0] grant,
    output logic               grant_valid,
    output logic [IO_W-1:0]    grant_idx
);

    state_t               r_state;
    logic [IO_SIZE-1:0]   r_grant;
    logic [IO_W-1:0]      r_grant_idx;
    logic [IO_W-1:0]      r_ptr;

    logic                 w_req_held;
    logic                 w_tail_held;
    logic                 w_release;
    logic [IO_W-1:0]      w_ptr_inc;
    logic [IO_W-1:0]      w_arb_ptr;
    logic [IO_SIZE-1:0]   w_arb_req;
    logic [IO_SIZE-1:0]   w_rot;
    logic                 w_found;
    logic [IO_W-1:0]      w_enc;
    logic [IO_W:0]        w_sum;
    logic [IO_W-1:0]      w_win;
    logic [IO_SIZE-1:0]   w_win_onehot;

    // r_grant is one-hot on r_grant_idx, so masking with it selects the
    // granted input's request/tail bit without a variable index.
    assign w_req_held  = |(request & r_grant);
    assign w_tail_held = |(tail & r_grant);

    // Release on tail acceptance or on the winner withdrawing its request
    assign w_release = (r_state == C_ST_GRANT) && ((ack && w_tail_held) || !w_req_held);

    assign w_ptr_inc = (r_grant_idx == IO_W'(IO_SIZE - 1)) ? '0 : r_grant_idx + IO_W'(1);

    // On release, arbitrate with the advanced pointer and the releasing
    // input masked out so it cannot win back-to-back.
    assign w_arb_ptr = w_release ? w_ptr_inc : r_ptr;
    assign w_arb_req = w_release ? (request & ~r_grant) : request;

    // Rotate right by the pointer: w_rot[i] = w_arb_req[(i + ptr) mod IO_SIZE]
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < IO_SIZE; i++) begin
            for (int k = 0; k < IO_SIZE; k++) begin
                if (((i + int'(w_arb_ptr)) % IO_SIZE) == k) begin
                    w_rot[i] = w_arb_req[k];
                end
            end
        end
    end

    rr_x_in_arb_prio_enc #(
        .IO_SIZE (IO_SIZE),
        .IO_W    (IO_W)
    ) u_prio_enc (
        .req   (w_rot),
        .found (w_found),
        .enc   (w_enc)
    );

    // Map the rotated winner back to an absolute index (modulo IO_SIZE)
    assign w_sum = {1'b0, w_enc} + {1'b0, w_arb_ptr};
    assign w_win = (w_sum >= (IO_W + 1)'(IO_SIZE)) ? IO_W'(w_sum - (IO_W + 1)'(IO_SIZE))
                                                   : IO_W'(w_sum);
    assign w_win_onehot = IO_SIZE'(1) << w_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= C_ST_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else if (r_state == C_ST_IDLE) begin
            if (w_found) begin
                r_grant     <= w_win_onehot;
                r_grant_idx <= w_win;
                r_state     <= C_ST_GRANT;
            end
        end else begin
            // Locked: only a release changes anything
            if (w_release) begin
                r_ptr <= w_ptr_inc;
                if (w_found) begin
                    r_grant     <= w_win_onehot;
                    r_grant_idx <= w_win;
                end else begin
                    r_grant     <= '0;
                    r_grant_idx <= '0;
                    r_state     <= C_ST_IDLE;
                end
            end
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = (r_state == C_ST_GRANT);

endmodule : rr_x_in_arb
`default_nettype wire
